// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: exception codes, access sizes, FSM states.
// Also holds the lane, store-replication and load-extension helpers.
package mem_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_RD_REQ,
        ST_RD_WAIT
    } state_t;

    function automatic logic [3:0] size_lanes(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    size_lanes = 4'b0001 << off;
            SZ_H:    size_lanes = off[1] ? 4'b1100 : 4'b0011;
            default: size_lanes = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_B:    replicate_wdata = {4{wd[7:0]}};
            SZ_H:    replicate_wdata = {2{wd[15:0]}};
            default: replicate_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [1:0] size, input logic sign,
                                                input logic [1:0] off, input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    extend_load = {{24{sign & sh[7]}}, sh[7:0]};
            SZ_H:    extend_load = {{16{sign & sh[15]}}, sh[15:0]};
            default: extend_load = sh;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer.sv
// In-order posted-store buffer with a parallel word-address match port (youngest entry wins).
// Latency: pushed entry visible at head the cycle after push; match is combinational.
// Backpressure: o_full blocks pushes; pops only take effect when non-empty.
module store_buffer #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [3:0]        i_push_byteen,
    input  logic [31:0]       i_push_wdata,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [3:0]        o_head_byteen,
    output logic [31:0]       o_head_wdata,
    input  logic [ADDR_W-1:0] i_match_addr,
    output logic              o_match_hit,
    output logic [3:0]        o_match_byteen,
    output logic [31:0]       o_match_wdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_addr   [DEPTH];
    logic [3:0]        r_byteen [DEPTH];
    logic [31:0]       r_wdata  [DEPTH];
    logic [IDX_W-1:0]  r_wr_ptr;
    logic [IDX_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;
    logic [IDX_W-1:0]  w_idx;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        next_idx = (int'(idx) == DEPTH - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    assign o_full        = (r_count == CNT_W'(DEPTH));
    assign o_empty       = (r_count == '0);
    assign w_push        = i_push && !o_full;
    assign w_pop         = i_pop && !o_empty;
    assign o_head_addr   = r_addr[r_rd_ptr];
    assign o_head_byteen = r_byteen[r_rd_ptr];
    assign o_head_wdata  = r_wdata[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_idx(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_idx(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr]   <= i_push_addr;
            r_byteen[r_wr_ptr] <= i_push_byteen;
            r_wdata[r_wr_ptr]  <= i_push_wdata;
        end
    end

    // Walk oldest to youngest so the last hit is the youngest store to that word.
    always_comb begin
        o_match_hit    = 1'b0;
        o_match_byteen = '0;
        o_match_wdata  = '0;
        w_idx          = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = IDX_W'((int'(r_rd_ptr) + k) % DEPTH);
            if (k < int'(r_count) && r_addr[w_idx] == i_match_addr) begin
                o_match_hit    = 1'b1;
                o_match_byteen = r_byteen[w_idx];
                o_match_wdata  = r_wdata[w_idx];
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: region/alignment checks, posted stores via store_buffer, blocking loads.
// Latency: store/exception response 1 cycle after accept; loads after drain plus bus round trip.
// Backpressure: o_req_ready low outside IDLE or when the store buffer is full. SB_FWD_EN enables store-to-load forwarding.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int                            ADDR_W      = 32,
    parameter int                            NUM_REGIONS = 4,
    parameter int                            BUF_DEPTH   = 2,
    parameter logic [ADDR_W*NUM_REGIONS-1:0] REGION_BASE = {32'h7F20, 32'h7F10, 32'h7F00, 32'h0000},
    parameter logic [ADDR_W*NUM_REGIONS-1:0] REGION_RLIM = {32'h7F23, 32'h7F1B, 32'h7F0B, 32'h2FFF},
    parameter logic [ADDR_W*NUM_REGIONS-1:0] REGION_WLIM = {32'h7F23, 32'h7F17, 32'h7F07, 32'h2FFF},
    parameter logic [NUM_REGIONS-1:0]        REGION_SUBW = 4'b1001
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_sign,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [4:0]        i_req_exc,
    input  logic              i_req_kill,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic [4:0]        o_resp_exc,
    output logic              o_bus_valid,
    input  logic              i_bus_ready,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [3:0]        o_bus_byteen,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_rvalid,
    input  logic [31:0]       i_bus_rdata
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ld_addr;
    logic [1:0]        r_ld_size;
    logic              r_ld_sign;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic [4:0]        r_resp_exc;

    logic              w_fire, w_push, w_pop, w_bad, w_misalign, w_fwd;
    logic              w_hit, w_subw;
    logic [ADDR_W-1:0] w_wlim, w_word_addr;
    logic [3:0]        w_lanes;
    logic              w_sb_full, w_sb_empty, w_match_hit;
    logic [ADDR_W-1:0] w_head_addr;
    logic [3:0]        w_head_byteen, w_match_byteen;
    logic [31:0]       w_head_wdata, w_match_wdata;

    assign o_req_ready  = (r_state == ST_IDLE) && !w_sb_full;
    assign w_fire       = i_req_valid && o_req_ready && !i_req_kill;
    assign w_lanes      = size_lanes(i_req_size, i_req_addr[1:0]);
    assign w_word_addr  = {i_req_addr[ADDR_W-1:2], 2'b00};
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_exc   = r_resp_exc;

    // Lowest-index region whose readable window contains the address.
    always_comb begin
        w_hit  = 1'b0;
        w_subw = 1'b0;
        w_wlim = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!w_hit && i_req_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]
                       && i_req_addr <= REGION_RLIM[i*ADDR_W +: ADDR_W]) begin
                w_hit  = 1'b1;
                w_subw = REGION_SUBW[i];
                w_wlim = REGION_WLIM[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_misalign = (i_req_size == SZ_H) ? i_req_addr[0]
                      : (i_req_size == SZ_B) ? 1'b0
                      : (i_req_addr[1:0] != 2'b00);
    assign w_bad = w_misalign || !w_hit || (i_req_we && i_req_addr > w_wlim)
                || ((i_req_size == SZ_B || i_req_size == SZ_H) && !w_subw);
    assign w_push = w_fire && i_req_we && (i_req_exc == EXC_NONE) && !w_bad;

`ifdef SB_FWD_EN
    assign w_fwd = w_match_hit && ((w_match_byteen & w_lanes) == w_lanes);
`else
    logic w_unused_fwd;
    assign w_fwd        = 1'b0;
    assign w_unused_fwd = ^{w_match_hit, w_match_byteen, w_match_wdata};
`endif

    store_buffer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (BUF_DEPTH)
    ) u_sb (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_push         (w_push),
        .i_push_addr    (w_word_addr),
        .i_push_byteen  (w_lanes),
        .i_push_wdata   (replicate_wdata(i_req_size, i_req_wdata)),
        .i_pop          (w_pop),
        .o_full         (w_sb_full),
        .o_empty        (w_sb_empty),
        .o_head_addr    (w_head_addr),
        .o_head_byteen  (w_head_byteen),
        .o_head_wdata   (w_head_wdata),
        .i_match_addr   (w_word_addr),
        .o_match_hit    (w_match_hit),
        .o_match_byteen (w_match_byteen),
        .o_match_wdata  (w_match_wdata)
    );

    // The read command owns the bus in RD_REQ; otherwise the buffer head drains.
    always_comb begin
        o_bus_valid  = 1'b0;
        o_bus_we     = 1'b0;
        o_bus_addr   = '0;
        o_bus_byteen = '0;
        o_bus_wdata  = '0;
        w_pop        = 1'b0;
        if (r_state == ST_RD_REQ) begin
            o_bus_valid = 1'b1;
            o_bus_addr  = {r_ld_addr[ADDR_W-1:2], 2'b00};
        end else if ((r_state == ST_IDLE || r_state == ST_DRAIN) && !w_sb_empty) begin
            o_bus_valid  = 1'b1;
            o_bus_we     = 1'b1;
            o_bus_addr   = w_head_addr;
            o_bus_byteen = w_head_byteen;
            o_bus_wdata  = w_head_wdata;
            w_pop        = i_bus_ready;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_ld_addr    <= '0;
            r_ld_size    <= SZ_B;
            r_ld_sign    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_exc   <= EXC_NONE;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_resp_rdata <= '0;
                        r_resp_exc   <= EXC_NONE;
                        if (i_req_exc != EXC_NONE) begin
                            r_resp_valid <= 1'b1;
                            r_resp_exc   <= i_req_exc;
                        end else if (w_bad) begin
                            r_resp_valid <= 1'b1;
                            r_resp_exc   <= i_req_we ? EXC_ADES : EXC_ADEL;
                        end else if (i_req_we) begin
                            r_resp_valid <= 1'b1;
                        end else if (w_fwd) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= extend_load(i_req_size, i_req_sign, i_req_addr[1:0], w_match_wdata);
                        end else begin
                            r_ld_addr <= i_req_addr;
                            r_ld_size <= i_req_size;
                            r_ld_sign <= i_req_sign;
                            r_state   <= w_sb_empty ? ST_RD_REQ : ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN:   if (w_sb_empty) r_state <= ST_RD_REQ;
                ST_RD_REQ:  if (i_bus_ready) r_state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (i_bus_rvalid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_exc   <= EXC_NONE;
                        r_resp_rdata <= extend_load(r_ld_size, r_ld_sign, r_ld_addr[1:0], i_bus_rdata);
                        r_state      <= ST_IDLE;
                    end
                end
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected responses and bus commands; a monitor pops and compares.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req_valid = 1'b0, i_req_we = 1'b0, i_req_sign = 1'b0, i_req_kill = 1'b0;
    logic [1:0]  i_req_size = SZ_W;
    logic [31:0] i_req_addr = '0, i_req_wdata = '0;
    logic [4:0]  i_req_exc = EXC_NONE;
    logic        i_bus_ready = 1'b1, i_bus_rvalid = 1'b0;
    logic [31:0] i_bus_rdata = '0;
    logic        o_req_ready, o_resp_valid, o_bus_valid, o_bus_we;
    logic [31:0] o_resp_rdata, o_bus_addr, o_bus_wdata;
    logic [4:0]  o_resp_exc;
    logic [3:0]  o_bus_byteen;

    typedef struct { logic [31:0] rdata; logic [4:0] exc; int tag; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; int tag; } bus_t;

    resp_t       exp_resp[$];
    bus_t        exp_bus[$];
    int          total = 0, bad = 0;
    logic [31:0] rd_word = '0;
    bit          rd_pend = 0, no_rd = 0, late_rv = 0;

    mem_access_unit dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_size(i_req_size), .i_req_sign(i_req_sign), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .i_req_exc(i_req_exc), .i_req_kill(i_req_kill),
        .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_exc(o_resp_exc),
        .o_bus_valid(o_bus_valid), .i_bus_ready(i_bus_ready), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_byteen(o_bus_byteen), .o_bus_wdata(o_bus_wdata),
        .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin : monitor
        resp_t er;
        bus_t  eb;
        if (o_resp_valid) begin
            total++;
            if (exp_resp.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected got rdata=%h exc=%0d", o_resp_rdata, o_resp_exc);
            end else begin
                er = exp_resp.pop_front();
                if (o_resp_rdata !== er.rdata || o_resp_exc !== er.exc) begin
                    bad++;
                    $display("FAIL resp_%0d got rdata=%h exc=%0d want rdata=%h exc=%0d",
                             er.tag, o_resp_rdata, o_resp_exc, er.rdata, er.exc);
                end
            end
        end
        if (o_bus_valid && i_bus_ready) begin
            total++;
            if (!o_bus_we) rd_pend = 1;
            if (exp_bus.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected got we=%b addr=%h be=%b wd=%h",
                         o_bus_we, o_bus_addr, o_bus_byteen, o_bus_wdata);
            end else begin
                eb = exp_bus.pop_front();
                if (o_bus_we !== eb.we || o_bus_addr !== eb.addr ||
                    o_bus_byteen !== eb.be || o_bus_wdata !== eb.wd) begin
                    bad++;
                    $display("FAIL bus_%0d got we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                             eb.tag, o_bus_we, o_bus_addr, o_bus_byteen, o_bus_wdata,
                             eb.we, eb.addr, eb.be, eb.wd);
                end
            end
        end
    end

    // Memory model: returns rd_word the cycle after an accepted read command.
    always @(posedge i_clk) begin
        #1;
        if ((rd_pend && !no_rd) || late_rv) begin
            i_bus_rvalid = 1'b1;
            i_bus_rdata  = rd_word;
        end else begin
            i_bus_rvalid = 1'b0;
        end
        rd_pend = 0;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic er(input logic [31:0] rdata, input logic [4:0] exc, input int tag);
        exp_resp.push_back('{rdata: rdata, exc: exc, tag: tag});
    endtask

    task automatic eb(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd, input int tag);
        exp_bus.push_back('{we: we, addr: addr, be: be, wd: wd, tag: tag});
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] exc, input bit chk_next, input string name);
        int n;
        i_req_valid = 1'b1; i_req_we = we; i_req_size = sz; i_req_sign = sgn;
        i_req_addr = addr; i_req_wdata = wd; i_req_exc = exc;
        n = 0;
        #1;
        while (!o_req_ready && n < 300) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL %s accept timeout", name);
        end
        @(posedge i_clk); #1;
        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_exc = EXC_NONE;
        if (chk_next) chk({name, "_resp_next"}, 32'(o_resp_valid), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_resp.size() != 0 || exp_bus.size() != 0) && n < 300) begin
            @(posedge i_clk);
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL %s timeout pending resp=%0d bus=%0d", name, exp_resp.size(), exp_bus.size());
            exp_resp.delete();
            exp_bus.delete();
        end
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        chk("rst_req_ready", 32'(o_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        chk("rst_bus_valid", 32'(o_bus_valid), 32'd0);
        chk("rst_bus_we", 32'(o_bus_we), 32'd0);
        chk("rst_bus_byteen", 32'(o_bus_byteen), 32'd0);
        chk("rst_bus_wdata", o_bus_wdata, 32'd0);

        // Word store, byte/half stores and lane replication.
        eb(1, 32'h10, 4'b1111, 32'h1234_5678, 1); er(0, EXC_NONE, 1);
        issue(1, SZ_W, 0, 32'h10, 32'h1234_5678, EXC_NONE, 1, "sw");
        eb(1, 32'h0, 4'b1000, 32'hABAB_ABAB, 2); er(0, EXC_NONE, 2);
        issue(1, SZ_B, 0, 32'h3, 32'h0000_00AB, EXC_NONE, 1, "sb3");
        eb(1, 32'h4, 4'b1100, 32'hBEEF_BEEF, 3); er(0, EXC_NONE, 3);
        issue(1, SZ_H, 0, 32'h6, 32'h0000_BEEF, EXC_NONE, 1, "sh6");
        eb(1, 32'h0, 4'b0010, 32'h5A5A_5A5A, 4); er(0, EXC_NONE, 4);
        issue(1, SZ_B, 0, 32'h1, 32'h0000_005A, EXC_NONE, 1, "sb1");
        wait_drain("stores");

        // Loads with extraction and extension.
        rd_word = 32'hAB00_0000;
        eb(0, 32'h0, 4'b0000, 32'h0, 10); er(32'hFFFF_FFAB, EXC_NONE, 10);
        issue(0, SZ_B, 1, 32'h3, 0, EXC_NONE, 0, "lb"); wait_drain("lb");
        eb(0, 32'h0, 4'b0000, 32'h0, 11); er(32'h0000_00AB, EXC_NONE, 11);
        issue(0, SZ_B, 0, 32'h3, 0, EXC_NONE, 0, "lbu"); wait_drain("lbu");
        rd_word = 32'h8001_1234;
        eb(0, 32'h0, 4'b0000, 32'h0, 12); er(32'hFFFF_8001, EXC_NONE, 12);
        issue(0, SZ_H, 1, 32'h2, 0, EXC_NONE, 0, "lh"); wait_drain("lh");
        eb(0, 32'h0, 4'b0000, 32'h0, 13); er(32'h0000_8001, EXC_NONE, 13);
        issue(0, SZ_H, 0, 32'h2, 0, EXC_NONE, 0, "lhu"); wait_drain("lhu");

        // Exceptions and region limits.
        er(0, EXC_ADEL, 20); issue(0, SZ_W, 0, 32'h2, 0, EXC_NONE, 1, "lw_mis");
        er(0, 5'd12, 21);    issue(0, SZ_W, 0, 32'h2, 0, 5'd12, 1, "exc_pass");
        er(0, EXC_ADES, 22); issue(1, SZ_H, 0, 32'h7F00, 32'h1, EXC_NONE, 1, "sh_nosubw");
        er(0, EXC_ADES, 23); issue(1, SZ_W, 0, 32'h7F08, 32'h1, EXC_NONE, 1, "sw_wlim");
        er(0, EXC_ADES, 24); issue(1, SZ_B, 0, 32'h7F11, 32'h1, EXC_NONE, 1, "sb_r2");
        er(0, EXC_ADEL, 25); issue(0, SZ_W, 0, 32'h4000, 0, EXC_NONE, 1, "lw_unmapped");
        wait_drain("exc");
        rd_word = 32'hCAFE_F00D;
        eb(0, 32'h7F08, 4'b0000, 32'h0, 26); er(32'hCAFE_F00D, EXC_NONE, 26);
        issue(0, SZ_W, 0, 32'h7F08, 0, EXC_NONE, 0, "lw_rlim");
        eb(1, 32'h7F20, 4'b0010, 32'h5A5A_5A5A, 27); er(0, EXC_NONE, 27);
        issue(1, SZ_B, 0, 32'h7F21, 32'h0000_005A, EXC_NONE, 1, "sb_r3");
        wait_drain("region");

        // Buffer full backpressure and FIFO drain order.
        i_bus_ready = 1'b0;
        eb(1, 32'h40, 4'b1111, 32'h1111_1111, 30); er(0, EXC_NONE, 30);
        issue(1, SZ_W, 0, 32'h40, 32'h1111_1111, EXC_NONE, 1, "st_a");
        eb(1, 32'h44, 4'b1111, 32'h2222_2222, 31); er(0, EXC_NONE, 31);
        issue(1, SZ_W, 0, 32'h44, 32'h2222_2222, EXC_NONE, 1, "st_b");
        chk("full_ready", 32'(o_req_ready), 32'd0);
        eb(1, 32'h48, 4'b1111, 32'h3333_3333, 32); er(0, EXC_NONE, 32);
        fork
            issue(1, SZ_W, 0, 32'h48, 32'h3333_3333, EXC_NONE, 0, "st_c");
            begin
                repeat (3) @(posedge i_clk);
                #2;
                chk("third_held", 32'(o_req_ready), 32'd0);
                i_bus_ready = 1'b1;
            end
        join
        wait_drain("full");

        // Store then load to the same word with a stalled bus.
        i_bus_ready = 1'b0;
        eb(1, 32'h20, 4'b1111, 32'h1122_3344, 40); er(0, EXC_NONE, 40);
        issue(1, SZ_W, 0, 32'h20, 32'h1122_3344, EXC_NONE, 1, "st_fw");
`ifdef SB_FWD_EN
        er(32'h1122_3344, EXC_NONE, 41);
        issue(0, SZ_W, 0, 32'h20, 0, EXC_NONE, 0, "ld_fw");
        chk("fwd_resp_next", 32'(o_resp_valid), 32'd1);
`else
        rd_word = 32'h1122_3344;
        eb(0, 32'h20, 4'b0000, 32'h0, 41); er(32'h1122_3344, EXC_NONE, 41);
        issue(0, SZ_W, 0, 32'h20, 0, EXC_NONE, 0, "ld_fw");
        chk("load_waits_drain", 32'(o_resp_valid), 32'd0);
`endif
        repeat (5) @(posedge i_clk);
        #1 i_bus_ready = 1'b1;
        wait_drain("fwd");

        // Killed store: no response, nothing buffered.
        i_req_valid = 1; i_req_kill = 1; i_req_we = 1; i_req_size = SZ_W;
        i_req_addr = 32'h60; i_req_wdata = 32'hDEAD_BEEF;
        @(posedge i_clk); #1;
        i_req_valid = 0; i_req_kill = 0; i_req_we = 0;
        chk("kill_no_resp", 32'(o_resp_valid), 32'd0);
        chk("kill_no_bus", 32'(o_bus_valid), 32'd0);
        chk("kill_ready", 32'(o_req_ready), 32'd1);
        repeat (3) @(posedge i_clk); #1;

        // Reset in RD_WAIT; late rvalid must be ignored.
        no_rd = 1;
        eb(0, 32'h100, 4'b0000, 32'h0, 50);
        issue(0, SZ_W, 0, 32'h100, 0, EXC_NONE, 0, "ld_rst");
        repeat (3) @(posedge i_clk); #1;
        chk("rdwait_ready", 32'(o_req_ready), 32'd0);
        i_reset = 1'b1;
        @(posedge i_clk); #1 i_reset = 1'b0;
        no_rd = 0;
        chk("post_rst_ready", 32'(o_req_ready), 32'd1);
        @(negedge i_clk) late_rv = 1;
        @(posedge i_clk); #2 late_rv = 0;
        repeat (4) @(posedge i_clk); #1;

        // Reset discards buffered stores.
        i_bus_ready = 1'b0;
        er(0, EXC_NONE, 51);
        issue(1, SZ_W, 0, 32'h200, 32'h7777_7777, EXC_NONE, 1, "st_rst");
        @(posedge i_clk); #1 i_reset = 1'b1;
        @(posedge i_clk); #1 i_reset = 1'b0;
        i_bus_ready = 1'b1;
        repeat (4) @(posedge i_clk); #1;
        chk("rst_buf_empty_bus", 32'(o_bus_valid), 32'd0);

        wait_drain("final");
        chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
